// File: rtl/calibration_pattern_tx.sv
// LED address calibration sequencer: streams one bit-plane of every LED's address
// per step, then triggers a capture step. Define CAL_PATTERN_GRAY_EN for Gray-coded addresses.
`timescale 1ns/1ps

module calibration_pattern_tx #(
    parameter int                     NUM_LEDS          = 50,
    parameter int                     LED_ADDRESS_WIDTH = 10,
    parameter int                     COLOR_WIDTH       = 24,
    parameter logic [COLOR_WIDTH-1:0] ON_COLOR          = 24'hFFFFFF,
    parameter int                     SETTLE_CYCLES     = 1000
) (
    input  logic                                 clk_pixel,
    input  logic                                 rst_n,
    input  logic                                 start_in,
    input  logic                                 abort_in,
    output logic [COLOR_WIDTH-1:0]               color_out,
    output logic                                 color_valid_out,
    input  logic                                 color_ready_in,
    output logic [LED_ADDRESS_WIDTH-1:0]         led_index_out,
    output logic                                 start_step_out,
    output logic                                 should_overwrite_out,
    input  logic                                 step_busy_in,
    output logic [$clog2(LED_ADDRESS_WIDTH)-1:0] bit_index_out,
    output logic                                 busy_out,
    output logic                                 done_out
);

    localparam int LED_CNT_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BIT_W     = $clog2(LED_ADDRESS_WIDTH);

    localparam logic [LED_CNT_W-1:0] LAST_LED    = LED_CNT_W'(NUM_LEDS - 1);
    localparam logic [SETTLE_W-1:0]  LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_W-1:0]     LAST_BIT    = BIT_W'(LED_ADDRESS_WIDTH - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_STREAM    = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_TRIGGER   = 3'd3;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;
    localparam logic [2:0] ST_CLEAR     = 3'd6;

    logic [2:0]           state;
    logic [BIT_W-1:0]     bit_index;
    logic [LED_CNT_W-1:0] led_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic                 start_prev;
    logic                 start_edge;
    logic                 word_accepted;

    // Color for one LED in the bit-plane selected by bit_sel.
    function automatic logic [COLOR_WIDTH-1:0] pattern_word(
        input logic [LED_CNT_W-1:0] led,
        input logic [BIT_W-1:0]     bit_sel
    );
        logic [LED_ADDRESS_WIDTH-1:0] code;
        code = LED_ADDRESS_WIDTH'(led);
`ifdef CAL_PATTERN_GRAY_EN
        code = code ^ (code >> 1);
`endif
        return code[bit_sel] ? ON_COLOR : '0;
    endfunction

    assign start_edge    = start_in & ~start_prev;
    assign word_accepted = color_valid_out & color_ready_in;
    assign bit_index_out = bit_index;
    assign led_index_out = LED_ADDRESS_WIDTH'(led_cnt);
    assign busy_out      = (state != ST_IDLE);

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            bit_index            <= '0;
            led_cnt              <= '0;
            settle_cnt           <= '0;
            start_prev           <= 1'b1;
            color_out            <= '0;
            color_valid_out      <= 1'b0;
            start_step_out       <= 1'b0;
            should_overwrite_out <= 1'b0;
            done_out             <= 1'b0;
        end else begin
            start_prev           <= start_in;
            start_step_out       <= 1'b0;
            should_overwrite_out <= 1'b0;
            done_out             <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_edge && !abort_in) begin
                        state           <= ST_STREAM;
                        bit_index       <= '0;
                        led_cnt         <= '0;
                        color_valid_out <= 1'b1;
                        color_out       <= pattern_word('0, '0);
                    end
                end

                // An abort waits here until the word on the bus has been taken.
                ST_STREAM: begin
                    if (word_accepted) begin
                        if (abort_in) begin
                            state     <= ST_CLEAR;
                            led_cnt   <= '0;
                            color_out <= '0;
                        end else if (led_cnt == LAST_LED) begin
                            state           <= ST_SETTLE;
                            led_cnt         <= '0;
                            settle_cnt      <= '0;
                            color_out       <= '0;
                            color_valid_out <= 1'b0;
                        end else begin
                            led_cnt   <= led_cnt + 1'b1;
                            color_out <= pattern_word(led_cnt + 1'b1, bit_index);
                        end
                    end
                end

                ST_SETTLE: begin
                    if (abort_in) begin
                        state           <= ST_CLEAR;
                        led_cnt         <= '0;
                        color_out       <= '0;
                        color_valid_out <= 1'b1;
                    end else if (settle_cnt == LAST_SETTLE) begin
                        state                <= ST_TRIGGER;
                        start_step_out       <= 1'b1;
                        should_overwrite_out <= (bit_index == '0);
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_TRIGGER: begin
                    if (abort_in) begin
                        state           <= ST_CLEAR;
                        led_cnt         <= '0;
                        color_out       <= '0;
                        color_valid_out <= 1'b1;
                    end else begin
                        state <= ST_WAIT_BUSY;
                    end
                end

                ST_WAIT_BUSY: begin
                    if (abort_in) begin
                        state           <= ST_CLEAR;
                        led_cnt         <= '0;
                        color_out       <= '0;
                        color_valid_out <= 1'b1;
                    end else if (step_busy_in) begin
                        state <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (abort_in || (!step_busy_in && bit_index == LAST_BIT)) begin
                        state           <= ST_CLEAR;
                        led_cnt         <= '0;
                        color_out       <= '0;
                        color_valid_out <= 1'b1;
                    end else if (!step_busy_in) begin
                        state           <= ST_STREAM;
                        bit_index       <= bit_index + 1'b1;
                        led_cnt         <= '0;
                        color_valid_out <= 1'b1;
                        color_out       <= pattern_word('0, bit_index + 1'b1);
                    end
                end

                // Abort is ignored here so a clear in progress is never restarted.
                ST_CLEAR: begin
                    if (word_accepted) begin
                        if (led_cnt == LAST_LED) begin
                            state           <= ST_IDLE;
                            led_cnt         <= '0;
                            color_valid_out <= 1'b0;
                            done_out        <= 1'b1;
                        end else begin
                            led_cnt <= led_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    led_cnt         <= '0;
                    color_out       <= '0;
                    color_valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calibration_pattern_tx.sv
// Scoreboard bench for calibration_pattern_tx with a small strip (4 LEDs, 2 address bits).
`timescale 1ns/1ps

module tb_calibration_pattern_tx;

    localparam int          NUM_LEDS = 4;
    localparam int          LAW      = 2;
    localparam int          SETTLE   = 3;
    localparam logic [23:0] ON       = 24'hFFFFFF;

    typedef struct {
        logic [23:0] color;
        logic [1:0]  idx;
        logic        bitIdx;
        bit          checkBit;
    } word_t;

    logic        clk_pixel = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b1;
    logic        abort_in = 1'b0;
    logic [23:0] color_out;
    logic        color_valid_out;
    logic        color_ready_in = 1'b1;
    logic [1:0]  led_index_out;
    logic        start_step_out;
    logic        should_overwrite_out;
    logic        step_busy_in = 1'b0;
    logic [0:0]  bit_index_out;
    logic        busy_out;
    logic        done_out;

    int checks = 0;
    int failures = 0;

    word_t expQ[$];
    word_t monWord;
    int    transferCount = 0;
    int    triggerCount = 0;
    int    doneCount = 0;
    int    cycleCnt = 0;
    int    lastXferCycle = 0;
    logic  overwriteLog[$];
    int    gapLog[$];

    int    readyMode = 0;
    logic  readyManual = 1'b0;
    bit    busyStuck = 1'b0;
    int    busyLen = 3;

    logic [3:0] stepMask0;
    logic [3:0] stepMask1;

    calibration_pattern_tx #(
        .NUM_LEDS(NUM_LEDS),
        .LED_ADDRESS_WIDTH(LAW),
        .COLOR_WIDTH(24),
        .ON_COLOR(ON),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst_n(rst_n),
        .start_in(start_in),
        .abort_in(abort_in),
        .color_out(color_out),
        .color_valid_out(color_valid_out),
        .color_ready_in(color_ready_in),
        .led_index_out(led_index_out),
        .start_step_out(start_step_out),
        .should_overwrite_out(should_overwrite_out),
        .step_busy_in(step_busy_in),
        .bit_index_out(bit_index_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = toggle every cycle, 2 = follow readyManual.
    always begin
        @(posedge clk_pixel);
        #2;
        case (readyMode)
            1:       color_ready_in = ~color_ready_in;
            2:       color_ready_in = readyManual;
            default: color_ready_in = 1'b1;
        endcase
    end

    // Stand-in for the capture step FSM.
    always begin
        @(negedge clk_pixel);
        if (start_step_out && !busyStuck) begin
            repeat (2) @(posedge clk_pixel);
            #1 step_busy_in = 1'b1;
            repeat (busyLen) @(posedge clk_pixel);
            #1 step_busy_in = 1'b0;
        end
    end

    // Scoreboard monitor: pops one expected word per accepted transfer.
    always @(negedge clk_pixel) begin
        cycleCnt++;
        if (rst_n && color_valid_out && color_ready_in) begin
            transferCount++;
            lastXferCycle = cycleCnt;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", 32'(led_index_out) + 32'h100, 32'h0);
            end else begin
                monWord = expQ.pop_front();
                checkOutput("word_color", 32'(color_out), 32'(monWord.color));
                checkOutput("word_index", 32'(led_index_out), 32'(monWord.idx));
                if (monWord.checkBit)
                    checkOutput("word_bit_index", 32'(bit_index_out), 32'(monWord.bitIdx));
            end
        end
        if (start_step_out) begin
            triggerCount++;
            overwriteLog.push_back(should_overwrite_out);
            gapLog.push_back(cycleCnt - lastXferCycle);
        end
        if (done_out) doneCount++;
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic sampleNow();
        @(negedge clk_pixel);
        #1;
    endtask

    task automatic applyStimulus(input logic doStart, input logic doAbort);
        start_in = doStart;
        abort_in = doAbort;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
    endtask

    task automatic pushStep(input int step);
        logic [3:0] mask;
        word_t w;
        mask = (step == 0) ? stepMask0 : stepMask1;
        for (int led = 0; led < NUM_LEDS; led++) begin
            w.color    = mask[led] ? ON : 24'h0;
            w.idx      = 2'(led);
            w.bitIdx   = 1'(step);
            w.checkBit = 1'b1;
            expQ.push_back(w);
        end
    endtask

    task automatic pushClear();
        word_t w;
        for (int led = 0; led < NUM_LEDS; led++) begin
            w.color    = 24'h0;
            w.idx      = 2'(led);
            w.bitIdx   = 1'b0;
            w.checkBit = 1'b0;
            expQ.push_back(w);
        end
    endtask

    task automatic resetCounts();
        transferCount = 0;
        triggerCount  = 0;
        doneCount     = 0;
        overwriteLog.delete();
        gapLog.delete();
    endtask

    task automatic waitDone(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            sampleNow();
            if (doneCount > 0) break;
        end
        checkOutput("done_seen", 32'(doneCount > 0), 32'h1);
        repeat (3) sampleNow();
    endtask

    task automatic waitTransfers(input int n, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (transferCount >= n) break;
            sampleNow();
        end
        checkOutput("transfers_reached", 32'(transferCount >= n), 32'h1);
    endtask

    task automatic waitTrigger(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (triggerCount > 0) break;
            sampleNow();
        end
        checkOutput("trigger_seen", 32'(triggerCount > 0), 32'h1);
    endtask

    initial begin
`ifdef CAL_PATTERN_GRAY_EN
        stepMask0 = 4'b0110;
`else
        stepMask0 = 4'b1010;
`endif
        stepMask1 = 4'b1100;

        // Reset with start held high; releasing reset must not start a run.
        repeat (3) tick();
        sampleNow();
        checkOutput("rst_valid", 32'(color_valid_out), 32'h0);
        checkOutput("rst_color", 32'(color_out), 32'h0);
        checkOutput("rst_busy", 32'(busy_out), 32'h0);
        checkOutput("rst_done", 32'(done_out), 32'h0);
        checkOutput("rst_step", 32'(start_step_out), 32'h0);
        checkOutput("rst_index", 32'(led_index_out), 32'h0);
        checkOutput("rst_bit", 32'(bit_index_out), 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        sampleNow();
        checkOutput("held_start_busy", 32'(busy_out), 32'h0);
        start_in = 1'b0;
        repeat (2) tick();

        $display("[TB] basic two-step calibration");
        resetCounts();
        pushStep(0); pushStep(1); pushClear();
        applyStimulus(1'b1, 1'b0);
        sampleNow();
        checkOutput("busy_running", 32'(busy_out), 32'h1);
        waitDone(300);
        checkOutput("basic_queue_left", 32'(expQ.size()), 32'h0);
        checkOutput("basic_transfers", 32'(transferCount), 32'd12);
        checkOutput("basic_trigger_cycles", 32'(triggerCount), 32'd2);
        checkOutput("basic_done_cycles", 32'(doneCount), 32'd1);
        checkOutput("basic_idle_busy", 32'(busy_out), 32'h0);
        if (overwriteLog.size() >= 2) begin
            checkOutput("overwrite_step0", 32'(overwriteLog[0]), 32'h1);
            checkOutput("overwrite_step1", 32'(overwriteLog[1]), 32'h0);
            checkOutput("settle_gap0", 32'(gapLog[0]), 32'(SETTLE + 1));
            checkOutput("settle_gap1", 32'(gapLog[1]), 32'(SETTLE + 1));
        end else begin
            checkOutput("overwrite_log_size", 32'(overwriteLog.size()), 32'd2);
        end
        expQ.delete();

        $display("[TB] ready toggling every cycle");
        resetCounts();
        pushStep(0); pushStep(1); pushClear();
        readyMode = 1;
        applyStimulus(1'b1, 1'b0);
        waitDone(400);
        readyMode = 0;
        checkOutput("toggle_queue_left", 32'(expQ.size()), 32'h0);
        checkOutput("toggle_transfers", 32'(transferCount), 32'd12);
        checkOutput("toggle_triggers", 32'(triggerCount), 32'd2);
        expQ.delete();
        tick();

        $display("[TB] step busy never rises");
        resetCounts();
        busyStuck = 1'b1;
        pushStep(0); pushClear();
        applyStimulus(1'b1, 1'b0);
        waitTrigger(100);
        repeat (20) sampleNow();
        checkOutput("stuck_triggers", 32'(triggerCount), 32'd1);
        checkOutput("stuck_busy", 32'(busy_out), 32'h1);
        checkOutput("stuck_valid", 32'(color_valid_out), 32'h0);
        applyStimulus(1'b0, 1'b1);
        waitDone(100);
        busyStuck = 1'b0;
        checkOutput("stuck_queue_left", 32'(expQ.size()), 32'h0);
        checkOutput("stuck_done_cycles", 32'(doneCount), 32'd1);
        expQ.delete();

        $display("[TB] abort during settle of step 1");
        resetCounts();
        pushStep(0); pushStep(1); pushClear();
        applyStimulus(1'b1, 1'b0);
        waitTransfers(8, 200);
        tick();
        applyStimulus(1'b0, 1'b1);
        waitDone(100);
        repeat (10) sampleNow();
        checkOutput("settle_abort_triggers", 32'(triggerCount), 32'd1);
        checkOutput("settle_abort_transfers", 32'(transferCount), 32'd12);
        checkOutput("settle_abort_done", 32'(doneCount), 32'd1);
        checkOutput("settle_abort_queue", 32'(expQ.size()), 32'h0);
        expQ.delete();

        $display("[TB] abort and start together in idle");
        resetCounts();
        applyStimulus(1'b1, 1'b1);
        repeat (3) sampleNow();
        checkOutput("abort_start_busy", 32'(busy_out), 32'h0);
        checkOutput("abort_start_valid", 32'(color_valid_out), 32'h0);
        checkOutput("abort_start_xfers", 32'(transferCount), 32'h0);

        $display("[TB] abort while a word is stalled");
        resetCounts();
        readyMode = 2;
        readyManual = 1'b0;
        pushStep(0);
        expQ = expQ[0:1];
        pushClear();
        applyStimulus(1'b1, 1'b0);
        readyManual = 1'b1;
        tick();
        readyManual = 1'b0;
        abort_in = 1'b1;
        repeat (3) tick();
        sampleNow();
        checkOutput("stall_valid", 32'(color_valid_out), 32'h1);
        checkOutput("stall_color", 32'(color_out), 32'(stepMask0[1] ? ON : 24'h0));
        checkOutput("stall_index", 32'(led_index_out), 32'h1);
        checkOutput("stall_xfers", 32'(transferCount), 32'h1);
        readyManual = 1'b1;
        repeat (3) tick();
        abort_in = 1'b0;
        readyMode = 0;
        waitDone(100);
        checkOutput("stall_queue_left", 32'(expQ.size()), 32'h0);
        checkOutput("stall_transfers", 32'(transferCount), 32'd6);
        checkOutput("stall_done", 32'(doneCount), 32'd1);
        expQ.delete();

        $display("[TB] reset during wait-done");
        resetCounts();
        busyLen = 30;
        pushStep(0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (step_busy_in) break;
            sampleNow();
        end
        checkOutput("busy_seen", 32'(step_busy_in), 32'h1);
        repeat (2) sampleNow();
        start_in = 1'b1;
        rst_n = 1'b0;
        tick();
        sampleNow();
        checkOutput("midrst_valid", 32'(color_valid_out), 32'h0);
        checkOutput("midrst_color", 32'(color_out), 32'h0);
        checkOutput("midrst_busy", 32'(busy_out), 32'h0);
        checkOutput("midrst_bit", 32'(bit_index_out), 32'h0);
        checkOutput("midrst_step", 32'(start_step_out | should_overwrite_out), 32'h0);
        rst_n = 1'b1;
        repeat (10) sampleNow();
        checkOutput("midrst_no_restart", 32'(busy_out), 32'h0);
        checkOutput("midrst_no_done", 32'(doneCount), 32'h0);
        checkOutput("midrst_queue_left", 32'(expQ.size()), 32'h0);
        start_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/calibration_pattern_tx.md
CALIBRATION_PATTERN_TX -- requirements
Module: calibration_pattern_tx

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 50, number of LEDs on the strip.
REQ-002 SHALL have parameter LED_ADDRESS_WIDTH, default 10, number of address bits (steps) sent per calibration.
REQ-003 SHALL have parameter COLOR_WIDTH, default 24, width of one LED color word.
REQ-004 SHALL have parameter ON_COLOR, default 24'hFFFFFF, color sent for a lit LED; unlit LEDs SHALL be sent 0.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 1000, idle cycles after a pattern is streamed before a step is triggered.
REQ-006 SHALL have ports: clk_pixel input 1 pixel clock; rst_n input 1 reset (one clock; reset is synchronous and active-low).
REQ-007 SHALL have ports: start_in input 1 rising edge starts a full calibration; abort_in input 1 level, aborts the sequence.
REQ-008 SHALL have ports: color_out output COLOR_WIDTH LED color; color_valid_out output 1; color_ready_in input 1 strip driver accepts word; led_index_out output LED_ADDRESS_WIDTH index of the current word.
REQ-009 SHALL have ports: start_step_out output 1 one-cycle step trigger; should_overwrite_out output 1 first-step flag held with trigger; step_busy_in input 1 high while the capture step FSM is not IDLE.
REQ-010 SHALL have ports: bit_index_out output $clog2(LED_ADDRESS_WIDTH) current step; busy_out output 1; done_out output 1 one-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, STREAM, SETTLE, TRIGGER, WAIT_BUSY, WAIT_DONE, CLEAR.
REQ-012 In IDLE, a start_in 0->1 edge SHALL set bit_index to 0 and enter STREAM; levels held high SHALL NOT restart.
REQ-013 In STREAM, words SHALL be sent for LED 0..NUM_LEDS-1 in order, with one word transferred per cycle where color_valid_out && color_ready_in.
REQ-014 color_out and led_index_out SHALL be held stable while color_ready_in is low.
REQ-015 Word i SHALL be ON_COLOR when bit bit_index of code(i) is 1, else 0; code(i)=i.
REQ-016 After the word for LED NUM_LEDS-1 is accepted, the block SHALL deassert valid the next cycle and enter SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter TRIGGER.
REQ-018 TRIGGER SHALL assert start_step_out for exactly one cycle, with should_overwrite_out=1 iff bit_index==0, then enter WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL advance on step_busy_in=1; WAIT_DONE SHALL advance on step_busy_in=0.
REQ-020 On leaving WAIT_DONE: if bit_index==LED_ADDRESS_WIDTH-1, the block SHALL enter CLEAR; else it SHALL increment bit_index and re-enter STREAM.
REQ-021 CLEAR SHALL stream NUM_LEDS zero words, then pulse done_out for one cycle and return to IDLE.
REQ-022 abort_in high in any non-IDLE, non-CLEAR state SHALL enter CLEAR at the next edge; in CLEAR it SHALL not restart the clear; done_out SHALL still pulse.
REQ-023 When abort_in and a start edge occur in the same cycle in IDLE, abort SHALL win and the state SHALL stay IDLE.
REQ-024 An abort during STREAM SHALL not drop a word currently held valid without acceptance, and SHALL complete its transfer first.
REQ-025 busy_out SHALL be 1 in every state except IDLE.
REQ-026 Counters SHALL be sized by $clog2 of their bound; the LED counter SHALL never exceed NUM_LEDS-1.

Reset
REQ-027 On rst_n=0 at a clk_pixel edge: state=IDLE; bit_index=0; LED counter=0; all outputs 0.
REQ-028 Reset mid-operation SHALL abandon the sequence with no done_out pulse and no CLEAR stream.
REQ-029 The start edge detector SHALL reset to 1 so that start_in held high through reset does not start a sequence.

Configuration
REQ-030 With macro CAL_PATTERN_GRAY_EN defined, code(i) SHALL be i ^ (i>>1) (Gray code); without it, code(i)=i.
REQ-031 CAL_PATTERN_GRAY_EN SHALL change only the pattern, not timing or handshakes.

Verification
REQ-032 NUM_LEDS=4, LED_ADDRESS_WIDTH=2, SETTLE_CYCLES=3, ready=1, start pulse -> step0 colors 0,ON,0,ON; step1 0,0,ON,ON; two start_step_out pulses, first with overwrite=1; then 4 zero words and done_out.
REQ-033 color_ready_in toggled 1/0 each cycle during STREAM -> each word is held until accepted; exactly NUM_LEDS transfers per step.
REQ-034 step_busy_in held 0 for 20 cycles after trigger -> the block remains in WAIT_BUSY with no further trigger.
REQ-035 abort_in asserted in SETTLE of step 1 -> no second trigger; CLEAR emits NUM_LEDS zeros; done_out pulses once.
REQ-036 rst_n low in WAIT_DONE -> next cycle all outputs 0, no done_out; start_in held high through reset does not start.
REQ-037 With CAL_PATTERN_GRAY_EN defined, NUM_LEDS=4 -> step0 colors 0,ON,ON,0; step1 0,0,ON,ON.
